// File: rtl/seg_display_driver_pkg.sv
// rtl/seg_display_driver_pkg.sv - shared calculator display types, glyph and segment codes
package seg_display_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_FORMAT = 2'd2
    } state_t;

    typedef logic [3:0] glyph_t;

    localparam glyph_t GLYPH_ZERO  = 4'd0;
    localparam glyph_t GLYPH_MINUS = 4'd10;
    localparam glyph_t GLYPH_E     = 4'd11;
    localparam glyph_t GLYPH_R     = 4'd12;
    localparam glyph_t GLYPH_BLANK = 4'd15;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int REFRESH_DIV_DEFAULT = 100000;

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
    function automatic logic [19:0] dd_adjust(input logic [19:0] bcd);
        logic [19:0] res;
        res = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_display_driver_if.sv
// rtl/seg_display_driver_if.sv - result load and display pins of the seven-segment driver
interface seg_display_driver_if;
    logic [15:0] value;
    logic        load;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (output value, load, input busy, an, seg, dp);
    modport slave  (input value, load, output busy, an, seg, dp);
endinterface

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - combinational 4-bit glyph to active-low seven-segment lookup
module seg_glyph_decode
    import seg_display_driver_pkg::*;
(
    input  glyph_t     glyph,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (glyph)
            4'd0:        seg = SEG_0;
            4'd1:        seg = SEG_1;
            4'd2:        seg = SEG_2;
            4'd3:        seg = SEG_3;
            4'd4:        seg = SEG_4;
            4'd5:        seg = SEG_5;
            4'd6:        seg = SEG_6;
            4'd7:        seg = SEG_7;
            4'd8:        seg = SEG_8;
            4'd9:        seg = SEG_9;
            GLYPH_MINUS: seg = SEG_MINUS;
            GLYPH_E:     seg = SEG_E;
            GLYPH_R:     seg = SEG_R;
            default:     seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_driver.sv
// rtl/seg_display_driver.sv - signed result to sign+BCD conversion and 4-digit multiplexed scan
module seg_display_driver
    import seg_display_driver_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_display_driver_if.slave  bus
);

    localparam int              CW           = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]   REFRESH_LAST = CW'(REFRESH_DIV - 1);

    state_t         state_q, state_d;
    logic [15:0]    mag_q, mag_d;
    logic [19:0]    bcd_q, bcd_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic           neg_q, neg_d;
    glyph_t [3:0]   glyph_q, glyph_d;

    logic [CW-1:0]  refresh_q, refresh_d;
    logic [1:0]     idx_q, idx_d;
    logic [3:0]     an_q, an_d;
    logic [6:0]     seg_q, seg_d;

    logic [15:0]    mag_in;
    logic [19:0]    bcd_adj;
    glyph_t [3:0]   fmt_glyphs;
    logic [1:0]     msd;
    logic           out_of_range;
    glyph_t         cur_glyph;
    logic [6:0]     dec_seg;

    // -32768 negates to 16'h8000, which is exactly 32768 as unsigned
    assign mag_in  = bus.value[15] ? (~bus.value + 16'd1) : bus.value;
    assign bcd_adj = dd_adjust(bcd_q);

    // Positive overflow shows as a ten-thousands digit; negatives also lose the thousands digit to the sign
    assign out_of_range = (bcd_q[19:16] != 4'd0) || (neg_q && (bcd_q[15:12] != 4'd0));

    always_comb begin
        fmt_glyphs = {4{GLYPH_BLANK}};
        msd        = 2'd0;
        if (bcd_q[15:12] != 4'd0) begin
            msd = 2'd3;
        end else if (bcd_q[11:8] != 4'd0) begin
            msd = 2'd2;
        end else if (bcd_q[7:4] != 4'd0) begin
            msd = 2'd1;
        end
        for (int i = 0; i < 4; i++) begin
            if (2'(i) <= msd) begin
                fmt_glyphs[i] = bcd_q[4*i +: 4];
            end
        end
        if (neg_q) begin
            fmt_glyphs[msd + 2'd1] = GLYPH_MINUS;
        end
        if (out_of_range) begin
            fmt_glyphs = {GLYPH_E, GLYPH_R, GLYPH_R, GLYPH_BLANK};
        end
    end

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        neg_d     = neg_q;
        glyph_d   = glyph_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    neg_d     = bus.value[15];
                    mag_d     = mag_in;
                    bcd_d     = '0;
                    bit_cnt_d = 4'd0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                {bcd_d, mag_d} = {bcd_adj[18:0], mag_q, 1'b0};
                bit_cnt_d      = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    state_d = ST_FORMAT;
                end
            end
            ST_FORMAT: begin
                glyph_d = fmt_glyphs;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cur_glyph = glyph_q[idx_q];

    seg_glyph_decode u_decode (
        .glyph (cur_glyph),
        .seg   (dec_seg)
    );

    always_comb begin
        refresh_d = refresh_q + CW'(1);
        idx_d     = idx_q;
        if (refresh_q == REFRESH_LAST) begin
            refresh_d = '0;
            idx_d     = idx_q + 2'd1;
        end
        an_d  = ~(4'b0001 << idx_q);
        seg_d = dec_seg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mag_q     <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            neg_q     <= 1'b0;
            glyph_q   <= {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_ZERO};
            refresh_q <= '0;
            idx_q     <= 2'd0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
            neg_q     <= neg_d;
            glyph_q   <= glyph_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.dp   = 1'b1;

endmodule

// File: tb/tb_seg_display_driver.sv
// tb/tb_seg_display_driver.sv - scoreboard bench for seg_display_driver
module tb_seg_display_driver;

    localparam int DIV = 4;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S8 = 7'b0000000, S9 = 7'b0010000;
    localparam logic [6:0] SM = 7'b0111111, SE = 7'b0000110, SR = 7'b0101111, SB = 7'b1111111;

    typedef struct {
        string           name;
        logic [3:0][6:0] s;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_display_driver_if bus ();

    seg_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     checks = 0;
    int     errors = 0;
    frame_t frame_q[$];
    int     busy_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string why);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Frame monitor: skip the slot in progress, then compare the next four scan slots
    initial begin
        forever begin
            @(negedge clk);
            if (frame_q.size() > 0) begin
                frame_t     f;
                logic [3:0] prev;
                int         n;
                int         t;
                f    = frame_q[0];
                prev = bus.an;
                n    = 0;
                t    = 0;
                while (n < 4 && t < 100) begin
                    @(negedge clk);
                    t++;
                    if (bus.an !== prev) begin
                        prev = bus.an;
                        n++;
                        case (bus.an)
                            4'b1110: check({f.name, " digit0"}, 32'(bus.seg), 32'(f.s[0]));
                            4'b1101: check({f.name, " digit1"}, 32'(bus.seg), 32'(f.s[1]));
                            4'b1011: check({f.name, " digit2"}, 32'(bus.seg), 32'(f.s[2]));
                            4'b0111: check({f.name, " digit3"}, 32'(bus.seg), 32'(f.s[3]));
                            default: fail({f.name, " an"}, $sformatf("an=%b is not one-hot low", bus.an));
                        endcase
                    end
                end
                if (n < 4) fail({f.name, " scan"}, "scan timed out");
                void'(frame_q.pop_front());
            end
        end
    end

    // Busy monitor: measure each busy pulse in cycles and compare with the queued length
    initial begin
        int cnt;
        int exp;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                cnt++;
            end else if (cnt > 0) begin
                if (busy_q.size() > 0) begin
                    exp = busy_q.pop_front();
                    check("busy_len", 32'(cnt), 32'(exp));
                end else begin
                    fail("busy_len", $sformatf("unexpected busy pulse of %0d", cnt));
                end
                cnt = 0;
            end
        end
    end

    task automatic do_load(input logic [15:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (bus.busy !== 1'b0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy !== 1'b0) fail({name, " idle"}, "busy never dropped");
    endtask

    task automatic push_frame(input string name, input logic [3:0][6:0] s);
        frame_t f;
        f.name = name;
        f.s    = s;
        frame_q.push_back(f);
    endtask

    task automatic wait_frames(input string name);
        int t;
        t = 0;
        while (frame_q.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (frame_q.size() > 0) fail({name, " frame"}, "frame check never completed");
    endtask

    task automatic run_value(input string name, input logic [15:0] v, input logic [3:0][6:0] s);
        busy_q.push_back(17);
        do_load(v);
        wait_idle(name);
        push_frame(name, s);
        wait_frames(name);
    endtask

    logic [3:0] an_tab [4];

    initial begin
        an_tab[0] = 4'b1110;
        an_tab[1] = 4'b1101;
        an_tab[2] = 4'b1011;
        an_tab[3] = 4'b0111;
        bus.value = 16'd0;
        bus.load  = 1'b0;
        rst       = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check("reset an", 32'(bus.an), 32'h0F);
            check("reset seg", 32'(bus.seg), 32'(SB));
            check("reset busy", 32'(bus.busy), 32'h0);
        end
        rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check($sformatf("scan an %0d", k), 32'(bus.an), 32'(an_tab[k / 4]));
            check($sformatf("scan seg %0d", k), 32'(bus.seg), (k < 4) ? 32'(S0) : 32'(SB));
        end
        check("dp", 32'(bus.dp), 32'h1);

        run_value("v1234",   16'd1234,  {S1, S2, S3, S4});
        run_value("vm5",     16'hFFFB,  {SB, SB, SM, S5});
        run_value("v10000",  16'd10000, {SE, SR, SR, SB});
        run_value("vm1000",  16'hFC18,  {SE, SR, SR, SB});
        run_value("vm32768", 16'h8000,  {SE, SR, SR, SB});
        run_value("vm999",   16'hFC19,  {SM, S9, S9, S9});
        run_value("v9999",   16'd9999,  {S9, S9, S9, S9});
        run_value("v0",      16'd0,     {SB, SB, SB, S0});

        // Second load on busy cycle 5 must be ignored
        busy_q.push_back(17);
        do_load(16'd42);
        repeat (3) @(negedge clk);
        do_load(16'd7777);
        wait_idle("v42");
        push_frame("v42", {SB, SB, S4, S2});
        wait_frames("v42");

        // Reset during conversion: busy is cut after 8 cycles
        busy_q.push_back(8);
        do_load(16'd8888);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", 32'(bus.busy), 32'h0);
        check("midrst an", 32'(bus.an), 32'h0F);
        rst = 1'b0;
        push_frame("midrst", {SB, SB, SB, S0});
        wait_frames("midrst");

        run_value("v8888", 16'd8888, {S8, S8, S8, S8});

        repeat (4) @(negedge clk);
        if (busy_q.size() != 0) fail("busy_q", "expected busy pulses never seen");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
